qspi_psram_ctrl: RTL and testbench
==================================

# qspi_psram_ctrl

Single-channel QSPI master that turns word-sized memory requests from the CPU/bus side into APS6404L-style SPI-mode PSRAM transactions. It sits directly upstream of the PSRAM device, and of the PSRAM bench model in simulation. It drives CMD 0x0B (fast read, dummy nibbles) and CMD 0x02 (write), with nibble-wide data on four lines. One request is in flight at a time. The response returns after CS# is released.

## Interface
- `DUMMY_NIBBLES`, default 4: dummy nibbles between address and read data.
- `ADDR_W`, default 24: address width sent on the bus, as 6 nibbles, MSB first.
- `clk`  in  1: system clock; `spi_clk` runs at `clk`/2.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_size`  in  2: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is treated as 4 bytes.
- `req_addr`  in  `ADDR_W`: start byte address.
- `req_wdata`  in  32: write data; byte i is `[8i+7:8i]`.
- `rsp_valid`  out  1: one-cycle pulse when a transaction completes (read or write).
- `rsp_rdata`  out  32: read data, little-endian, zero-extended above `req_size`; held until the next read completes.
- `spi_clk`  out  1: SPI clock, registered.
- `spi_cs_n`  out  1: chip select, active low.
- `spi_data_out`  out  4: nibble to the PSRAM.
- `spi_data_oe`  out  4: 4'hF = controller drives, 4'h0 = PSRAM drives.
- `spi_data_in`  in  4: nibble from the PSRAM.

## Operation
- States and transitions:
  - IDLE → CMD → ADDR → DUMMY → RDATA → DONE for reads.
  - IDLE → CMD → ADDR → WDATA → DONE for writes.
  - DONE → IDLE.
- Nibble counts per phase:
  - CMD: 2 nibbles, 0x0B or 0x02, high nibble first.
  - ADDR: 6 nibbles, `req_addr[23:20]` first.
  - DUMMY: `DUMMY_NIBBLES`.
  - Data: 2 × bytes.
- Byte order: bytes go out or come in ascending address order, byte 0 first. Within a byte the high nibble goes first. The PSRAM auto-increments the address, so unaligned start addresses are legal.
- Output enable: `spi_data_oe` = 4'hF in CMD, ADDR and WDATA; 4'h0 in DUMMY, RDATA, DONE and IDLE.
- Capture: `req_write`, `req_size`, `req_addr` and `req_wdata` are latched on accept. Later changes on the request port are ignored.
- Single 4-bit nibble counter and 32-bit shift register; the size is decoded into a last-nibble count at accept.

## Timing
- Reset values (asynchronous):
  - `spi_cs_n`=1, `spi_clk`=0, `spi_data_oe`=0, `spi_data_out`=0.
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0.
  - State = IDLE.
- Each nibble takes 2 `clk` cycles: a low phase, where `spi_clk`=0 and `spi_data_out`/`spi_data_oe` are updated, then a high phase, where `spi_clk`=1.
- Read sampling: `spi_data_in` is sampled on the `clk` edge that raises `spi_clk`. The PSRAM drives it on the preceding `spi_clk` fall.
- Cycle 0 is the accept edge.
  - Cycle 1: `spi_cs_n`=0, first CMD nibble, low phase.
  - Transaction of N nibbles occupies cycles 1..2N.
  - Cycle 2N+1: DONE, with `spi_cs_n`=1, `spi_clk`=0, `rsp_valid`=1, and `rsp_rdata` already updated.
  - Cycle 2N+2: IDLE, `req_ready`=1.
- Response latency (`rsp_valid` cycle):
  - Read, 4 B: N=20, cycle 41. Read, 1 B: cycle 29.
  - Write, 4 B: N=16, cycle 33. Write, 1 B: cycle 21.
- `spi_cs_n` stays high for at least 2 cycles between transactions (DONE + IDLE), even with `req_valid` held high.
- Reset mid-transaction: `spi_cs_n` rises asynchronously, no `rsp_valid` is produced, and a partial write is abandoned.

## Structure
- Package `qspi_psram_pkg` holds:
  - `CMD_READ`=8'h0B, `CMD_WRITE`=8'h02.
  - The state enum (IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, DONE).
  - Size encodings `SZ_1B`/`SZ_2B`/`SZ_4B`.
- Single module; no sub-module is warranted.

## Test plan
All scenarios run against the 8 KB PSRAM model.
- Write 0xDEADBEEF, size 4, to 0x100 → model bytes 0x100..0x103 = EF, BE, AD, DE; `rsp_valid` at cycle 33.
- Read, size 4, from 0x100 → `rsp_rdata`=0xDEADBEEF at cycle 41; `spi_data_oe`=0 from cycle 17 through cycle 41.
- Write 0x5A, size 1, to 0x103, then read size 4 from 0x100 → 0x5AADBEEF.
- Read, size 2, from unwritten 0x1FFE → 0x0000FFFF; unaligned read, size 4, from 0x101 (after test 1, model memory initialised to 0xFF) → 0xFFDEADBE.
- Assert `rst` at cycle 10 of a read → `spi_cs_n`=1 immediately, no `rsp_valid`; the next write/read pair completes correctly.
- `req_valid` held high with two queued requests → second accepted at cycle 2N+2; `spi_cs_n` high ≥2 cycles between them.

Source files
------------

// File: rtl/qspi_psram_pkg.sv
// Shared constants, state encoding and byte-order helpers for the QSPI PSRAM master.
package qspi_psram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam logic [1:0] SZ_1B = 2'd0;
  localparam logic [1:0] SZ_2B = 2'd1;
  localparam logic [1:0] SZ_4B = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    DONE
  } state_t;

  // Index of the final data nibble; size 3 falls through to the 4-byte case.
  function automatic logic [3:0] last_nibble(input logic [1:0] size);
    case (size)
      SZ_1B:   return 4'd1;
      SZ_2B:   return 4'd3;
      default: return 4'd7;
    endcase
  endfunction

  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // Received nibbles accumulate byte 0 first, so the low bytes of the shift
  // register hold the word in big-endian order and must be reversed.
  function automatic logic [31:0] rx_to_le(input logic [31:0] sr, input logic [1:0] size);
    case (size)
      SZ_1B:   return {24'd0, sr[7:0]};
      SZ_2B:   return {16'd0, sr[7:0], sr[15:8]};
      default: return byte_swap(sr);
    endcase
  endfunction

endpackage

// File: rtl/qspi_psram_ctrl.sv
// Single-request QSPI master issuing fast-read (0x0B) and write (0x02) PSRAM
// transactions, one nibble per two clk cycles.
module qspi_psram_ctrl
  import qspi_psram_pkg::*;
#(
  parameter int DUMMY_NIBBLES = 4,
  parameter int ADDR_W        = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              spi_clk,
  output logic              spi_cs_n,
  output logic [3:0]        spi_data_out,
  output logic [3:0]        spi_data_oe,
  input  logic [3:0]        spi_data_in
);

  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_NIBBLES - 1);

  state_t      state_reg;
  logic [3:0]  nib_cnt_reg;
  logic [3:0]  last_nib_reg;
  logic        is_write_reg;
  logic [1:0]  size_reg;
  logic [31:0] wdata_reg;
  logic [31:0] shift_reg;
  logic [23:0] addr24;

  generate
    if (ADDR_W >= 24) begin : g_addr_trunc
      assign addr24 = req_addr[23:0];
    end else begin : g_addr_ext
      assign addr24 = {{(24 - ADDR_W){1'b0}}, req_addr};
    end
  endgenerate

  // spi_clk doubles as the phase flag: low phase updates data, high phase ends the nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      spi_cs_n     <= 1'b1;
      spi_clk      <= 1'b0;
      spi_data_oe  <= 4'h0;
      spi_data_out <= 4'h0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      nib_cnt_reg  <= 4'd0;
      last_nib_reg <= 4'd0;
      is_write_reg <= 1'b0;
      size_reg     <= SZ_1B;
      wdata_reg    <= 32'd0;
      shift_reg    <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            is_write_reg <= req_write;
            size_reg     <= req_size;
            last_nib_reg <= last_nibble(req_size);
            wdata_reg    <= req_wdata;
            shift_reg    <= {(req_write ? CMD_WRITE : CMD_READ), addr24};
            spi_data_out <= req_write ? CMD_WRITE[7:4] : CMD_READ[7:4];
            spi_data_oe  <= 4'hF;
            spi_cs_n     <= 1'b0;
            spi_clk      <= 1'b0;
            nib_cnt_reg  <= 4'd0;
            req_ready    <= 1'b0;
            state_reg    <= CMD;
          end
        end

        CMD, ADDR, DUMMY, RDATA, WDATA: begin
          if (!spi_clk) begin
            spi_clk <= 1'b1;
            if (state_reg == RDATA) begin
              shift_reg <= {shift_reg[27:0], spi_data_in};
            end
          end else begin
            spi_clk     <= 1'b0;
            nib_cnt_reg <= nib_cnt_reg + 4'd1;
            case (state_reg)
              CMD: begin
                spi_data_out <= shift_reg[27:24];
                shift_reg    <= {shift_reg[27:0], 4'h0};
                if (nib_cnt_reg == 4'd1) begin
                  nib_cnt_reg <= 4'd0;
                  state_reg   <= ADDR;
                end
              end
              ADDR: begin
                if (nib_cnt_reg == 4'd5) begin
                  nib_cnt_reg <= 4'd0;
                  if (is_write_reg) begin
                    shift_reg    <= byte_swap(wdata_reg);
                    spi_data_out <= wdata_reg[7:4];
                    state_reg    <= WDATA;
                  end else begin
                    shift_reg    <= 32'd0;
                    spi_data_out <= 4'h0;
                    spi_data_oe  <= 4'h0;
                    state_reg    <= (DUMMY_NIBBLES == 0) ? RDATA : DUMMY;
                  end
                end else begin
                  spi_data_out <= shift_reg[27:24];
                  shift_reg    <= {shift_reg[27:0], 4'h0};
                end
              end
              DUMMY: begin
                if (nib_cnt_reg == DUMMY_LAST) begin
                  nib_cnt_reg <= 4'd0;
                  state_reg   <= RDATA;
                end
              end
              RDATA: begin
                if (nib_cnt_reg == last_nib_reg) begin
                  rsp_rdata <= rx_to_le(shift_reg, size_reg);
                  rsp_valid <= 1'b1;
                  spi_cs_n  <= 1'b1;
                  state_reg <= DONE;
                end
              end
              WDATA: begin
                if (nib_cnt_reg == last_nib_reg) begin
                  spi_data_out <= 4'h0;
                  spi_data_oe  <= 4'h0;
                  rsp_valid    <= 1'b1;
                  spi_cs_n     <= 1'b1;
                  state_reg    <= DONE;
                end else begin
                  spi_data_out <= shift_reg[27:24];
                  shift_reg    <= {shift_reg[27:0], 4'h0};
                end
              end
              default: state_reg <= IDLE;
            endcase
          end
        end

        DONE: begin
          req_ready <= 1'b1;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          spi_cs_n  <= 1'b1;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_psram_ctrl.sv
// Directed bench for qspi_psram_ctrl against an 8 KB behavioural QSPI PSRAM.
module tb_qspi_psram_ctrl;
  import qspi_psram_pkg::*;

  localparam int DUMMY = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        spi_clk;
  logic        spi_cs_n;
  logic [3:0]  spi_data_out;
  logic [3:0]  spi_data_oe;
  logic [3:0]  spi_data_in;

  always #5 clk = ~clk;

  qspi_psram_ctrl #(.DUMMY_NIBBLES(DUMMY), .ADDR_W(24)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_data_out(spi_data_out),
    .spi_data_oe(spi_data_oe), .spi_data_in(spi_data_in)
  );

  // PSRAM model: samples on spi_clk rise, drives read data after spi_clk fall.
  logic [7:0]  mem [0:8191];
  bit          mem_init_done = 1'b0;
  logic        prev_sclk = 1'b0;
  int          m_idx = 0;
  int          m_j;
  logic [7:0]  m_cmd = 8'h00;
  logic [23:0] m_addr = 24'h0;
  logic [3:0]  m_hi = 4'h0;
  logic [7:0]  m_b;
  logic [12:0] m_ix;

  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 8192; i++) mem[i] = 8'hFF;
      mem_init_done = 1'b1;
    end
    if (spi_cs_n !== 1'b0) begin
      m_idx = 0;
      spi_data_in = 4'h0;
    end else if (spi_clk === 1'b1 && prev_sclk === 1'b0) begin
      if (m_idx < 2) m_cmd = {m_cmd[3:0], spi_data_out};
      else if (m_idx < 8) m_addr = {m_addr[19:0], spi_data_out};
      else if (m_cmd == 8'h02) begin
        if (((m_idx - 8) % 2) == 0) m_hi = spi_data_out;
        else begin
          mem[m_addr[12:0]] = {m_hi, spi_data_out};
          m_addr = m_addr + 24'd1;
        end
      end
      m_idx++;
    end else if (spi_clk === 1'b0 && prev_sclk === 1'b1) begin
      if (m_cmd == 8'h0B && m_idx >= 8 + DUMMY) begin
        m_j = m_idx - 8 - DUMMY;
        m_ix = m_addr[12:0] + 13'(m_j / 2);
        m_b = mem[m_ix];
        spi_data_in = ((m_j % 2) == 0) ? m_b[7:4] : m_b[3:0];
      end
    end
    prev_sclk = spi_clk;
  end

  typedef struct {
    int          id;
    bit          write;
    logic [31:0] rdata;
    int          lat;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns #1 after the accept edge.
  task automatic issue(input int id, input bit w, input logic [1:0] sz, input logic [23:0] a,
                       input logic [31:0] wd, input logic [31:0] exp, input int lat, input bit hold);
    bit acc;
    acc = 1'b0;
    req_write = w; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      if (req_ready === 1'b1) acc = 1'b1;
      else @(negedge clk);
    end
    if (!acc) chk($sformatf("accept_timeout_t%0d", id), 32'd0, 32'd1);
    else begin
      @(posedge clk);
      sb_q.push_back('{id, w, exp, lat});
    end
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic collect(input int oe_from);
    sb_item_t it;
    bit got;
    bit oe_ok;
    got = 1'b0;
    oe_ok = 1'b1;
    for (int n = 1; n <= 200 && !got; n++) begin
      @(negedge clk);
      if (oe_from > 0 && n >= oe_from && spi_data_oe !== 4'h0) oe_ok = 1'b0;
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        if (sb_q.size() == 0) chk("sb_unexpected_rsp", 32'd1, 32'd0);
        else begin
          it = sb_q.pop_front();
          chk($sformatf("lat_t%0d", it.id), n, it.lat);
          chk($sformatf("done_cs_t%0d", it.id), {31'd0, spi_cs_n}, 32'd1);
          chk($sformatf("done_sclk_t%0d", it.id), {31'd0, spi_clk}, 32'd0);
          if (it.write) chk($sformatf("rdata_held_t%0d", it.id), rsp_rdata, last_rd);
          else begin
            chk($sformatf("rdata_t%0d", it.id), rsp_rdata, it.rdata);
            last_rd = it.rdata;
          end
        end
      end
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
    if (oe_from > 0) chk("oe_released", {31'd0, oe_ok}, 32'd1);
    @(negedge clk);
    chk("ready_after_done", {31'd0, req_ready}, 32'd1);
    chk("rsp_one_pulse", {31'd0, rsp_valid}, 32'd0);
  endtask

  sb_item_t b2b_it;
  int       gap;
  int       rdy_n;
  bit       seen_rsp;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_addr = 24'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, spi_clk}, 32'd0);
    chk("rst_oe", {28'd0, spi_data_oe}, 32'd0);
    chk("rst_dout", {28'd0, spi_data_out}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(1, 1'b1, SZ_4B, 24'h000100, 32'hDEADBEEF, 32'd0, 33, 1'b0);
    collect(0);
    chk("mem_100", {24'd0, mem[13'h100]}, 32'hEF);
    chk("mem_101", {24'd0, mem[13'h101]}, 32'hBE);
    chk("mem_102", {24'd0, mem[13'h102]}, 32'hAD);
    chk("mem_103", {24'd0, mem[13'h103]}, 32'hDE);

    issue(2, 1'b0, SZ_4B, 24'h000100, 32'd0, 32'hDEADBEEF, 41, 1'b0);
    collect(17);
    issue(3, 1'b0, SZ_4B, 24'h000101, 32'd0, 32'hFFDEADBE, 41, 1'b0);
    collect(17);
    issue(4, 1'b1, SZ_1B, 24'h000103, 32'h1234565A, 32'd0, 21, 1'b0);
    collect(0);
    chk("mem_103_b", {24'd0, mem[13'h103]}, 32'h5A);
    chk("mem_104_b", {24'd0, mem[13'h104]}, 32'hFF);
    issue(5, 1'b0, SZ_4B, 24'h000100, 32'd0, 32'h5AADBEEF, 41, 1'b0);
    collect(17);
    issue(6, 1'b0, SZ_2B, 24'h001FFE, 32'd0, 32'h0000FFFF, 33, 1'b0);
    collect(17);
    issue(7, 1'b0, SZ_1B, 24'h000100, 32'd0, 32'h000000EF, 29, 1'b0);
    collect(17);
    issue(8, 1'b0, 2'd3, 24'h000100, 32'd0, 32'h5AADBEEF, 41, 1'b0);
    collect(17);

    // Reset in the middle of a read.
    issue(20, 1'b0, SZ_4B, 24'h000100, 32'd0, 32'h5AADBEEF, 41, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("midrst_sclk", {31'd0, spi_clk}, 32'd0);
    chk("midrst_oe", {28'd0, spi_data_oe}, 32'd0);
    sb_q.delete();
    last_rd = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_rsp = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen_rsp = 1'b1;
    end
    chk("midrst_no_rsp", {31'd0, seen_rsp}, 32'd0);
    issue(21, 1'b1, SZ_4B, 24'h000200, 32'h12345678, 32'd0, 33, 1'b0);
    collect(0);
    issue(22, 1'b0, SZ_4B, 24'h000200, 32'd0, 32'h12345678, 41, 1'b0);
    collect(17);

    // Two requests with req_valid held high throughout.
    issue(30, 1'b1, SZ_4B, 24'h000300, 32'hCAFEF00D, 32'd0, 33, 1'b1);
    req_write = 1'b0; req_size = SZ_4B; req_addr = 24'h000300; req_wdata = 32'd0;
    gap = 0;
    rdy_n = 0;
    for (int n = 1; n <= 100 && rdy_n == 0; n++) begin
      @(negedge clk);
      if (spi_cs_n === 1'b1) gap++;
      if (rsp_valid === 1'b1) begin
        if (sb_q.size() == 0) chk("b2b_unexpected_rsp", 32'd1, 32'd0);
        else begin
          b2b_it = sb_q.pop_front();
          chk("b2b_write_lat", n, b2b_it.lat);
        end
      end
      if (req_ready === 1'b1) rdy_n = n;
    end
    chk("b2b_ready_cycle", rdy_n, 32'd34);
    chk("b2b_cs_gap_ge2", {31'd0, (gap >= 2)}, 32'd1);
    @(posedge clk);
    sb_q.push_back('{31, 1'b0, 32'hCAFEF00D, 41});
    #1;
    req_valid = 1'b0;
    collect(17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
